// File: rtl/alu_controller.sv
// alu_controller: 16-bit ALU with a one-hot 9-bit operation select.
// Drives a zero-latency combinational result and, one clock later, a
// registered copy of that result together with carry/zero/negative/overflow.
// Optional build macro: ALU_ONEHOT_CHECK_EN
//   defined   - a multi-hot select is rejected: result = 0, registers hold,
//               op_error pulses for one cycle.
//   undefined - a multi-hot select resolves to its lowest set bit;
//               op_error is tied to 0.
// Load rule: there is no handshake. Every rising edge that sees a legal
// (non-zero, resolved) select loads result_q and the flags. Any other edge
// leaves them holding.
module alu_controller #(
   parameter int WIDTH = 16,
   parameter int OPS   = 9
) (
   input  logic             clock,
   input  logic             reset,
   input  logic [WIDTH-1:0] a,
   input  logic [WIDTH-1:0] b,
   input  logic [OPS-1:0]   op_sel,
   output logic [WIDTH-1:0] result,
   output logic [WIDTH-1:0] result_q,
   output logic             carry,
   output logic             zero,
   output logic             negative,
   output logic             overflow,
   output logic             op_error
);

   localparam int OP_AND  = 0;
   localparam int OP_OR   = 1;
   localparam int OP_XOR  = 2;
   localparam int OP_ADD  = 3;
   localparam int OP_SUB  = 4;
   localparam int OP_SHL  = 5;
   localparam int OP_SHR  = 6;
   localparam int OP_NOTA = 7;
   localparam int OP_PASS = 8;

   localparam logic [OPS-1:0] ONE_OP = {{(OPS-1){1'b0}}, 1'b1};

   logic [OPS-1:0] op_eff;
   logic           multi_hot;
   logic [3:0]     shamt;
   logic [WIDTH:0] sum_ext;
   logic [WIDTH:0] diff_ext;
   logic [WIDTH:0] shl_ext;
   logic [WIDTH:0] shr_ext;
   logic           carry_c;
   logic           overflow_c;

   assign shamt    = b[3:0];
   assign sum_ext  = {1'b0, a} + {1'b0, b};
   assign diff_ext = {1'b0, a} - {1'b0, b};
   // Shifting with one spare bit beside the operand captures the last bit
   // shifted out; a zero shift leaves the spare bit 0, so carry is 0.
   assign shl_ext  = {1'b0, a} << shamt;
   assign shr_ext  = {a, 1'b0} >> shamt;

   assign multi_hot = (op_sel & (op_sel - ONE_OP)) != '0;

   // Resolve the raw select into the single operation actually executed.
   always_comb begin
      op_eff = '0;
`ifdef ALU_ONEHOT_CHECK_EN
      op_eff = multi_hot ? '0 : op_sel;
`else
      op_eff = op_sel & (~op_sel + ONE_OP);
`endif
   end

   // Combinational datapath: result plus the flags the next edge will load.
   always_comb begin
      result     = '0;
      carry_c    = 1'b0;
      overflow_c = 1'b0;
      if (op_eff[OP_AND]) begin
         result = a & b;
      end else if (op_eff[OP_OR]) begin
         result = a | b;
      end else if (op_eff[OP_XOR]) begin
         result = a ^ b;
      end else if (op_eff[OP_ADD]) begin
         result     = sum_ext[WIDTH-1:0];
         carry_c    = sum_ext[WIDTH];
         overflow_c = (a[WIDTH-1] == b[WIDTH-1]) &&
                      (sum_ext[WIDTH-1] != a[WIDTH-1]);
      end else if (op_eff[OP_SUB]) begin
         result     = diff_ext[WIDTH-1:0];
         carry_c    = diff_ext[WIDTH];
         overflow_c = (a[WIDTH-1] != b[WIDTH-1]) &&
                      (diff_ext[WIDTH-1] != a[WIDTH-1]);
      end else if (op_eff[OP_SHL]) begin
         result  = shl_ext[WIDTH-1:0];
         carry_c = shl_ext[WIDTH];
      end else if (op_eff[OP_SHR]) begin
         result  = shr_ext[WIDTH:1];
         carry_c = shr_ext[0];
      end else if (op_eff[OP_NOTA]) begin
         result = ~a;
      end else if (op_eff[OP_PASS]) begin
         result = b;
      end
   end

   // Result and status registers: load on a legal op, otherwise hold.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         result_q <= '0;
         carry    <= 1'b0;
         zero     <= 1'b1;
         negative <= 1'b0;
         overflow <= 1'b0;
      end else if (op_eff != '0) begin
         result_q <= result;
         carry    <= carry_c;
         zero     <= (result == '0);
         negative <= result[WIDTH-1];
         overflow <= overflow_c;
      end
   end

`ifdef ALU_ONEHOT_CHECK_EN
   logic op_error_q;

   // Illegal-select flag: set for exactly the cycle after a multi-hot select.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         op_error_q <= 1'b0;
      end else begin
         op_error_q <= multi_hot;
      end
   end

   assign op_error = op_error_q;
`else
   assign op_error = 1'b0;
`endif

endmodule

// File: tb/tb_alu_controller.sv
// tb_alu_controller: directed vectors with hand-computed results for
// alu_controller. A driver applies each vector and queues the expected
// outputs; a monitor pops one entry per falling edge and compares.
module tb_alu_controller;

   localparam int W = 16;

   typedef struct packed {
      logic [W-1:0] res;
      logic [W-1:0] res_q;
      logic         carry;
      logic         zero;
      logic         neg;
      logic         ovf;
      logic         err;
   } exp_t;

   logic         clock;
   logic         reset;
   logic [W-1:0] a;
   logic [W-1:0] b;
   logic [8:0]   op_sel;
   logic [W-1:0] result;
   logic [W-1:0] result_q;
   logic         carry;
   logic         zero;
   logic         negative;
   logic         overflow;
   logic         op_error;

   exp_t exp_q[$];
   int   checks = 0;
   int   errors = 0;

   // Model of the registered state, updated from hand-computed vectors.
   logic [W-1:0] m_q   = '0;
   logic         m_c   = 1'b0;
   logic         m_v   = 1'b0;

   alu_controller #(.WIDTH(W), .OPS(9)) dut (
      .clock    (clock),
      .reset    (reset),
      .a        (a),
      .b        (b),
      .op_sel   (op_sel),
      .result   (result),
      .result_q (result_q),
      .carry    (carry),
      .zero     (zero),
      .negative (negative),
      .overflow (overflow),
      .op_error (op_error)
   );

   // Clock: 10 time-unit period, rising edges at 5, 15, ...
   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   task automatic chk(input string name, input logic [W-1:0] act,
                      input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%h expected 0x%h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Apply one vector just after a falling edge and queue what the next
   // falling edge must show. load=1: registers take exp_res/c/v.
   // err=1: op_error expected high after the edge.
   task automatic issue(input logic [W-1:0] ta, input logic [W-1:0] tb,
                        input logic [8:0] top, input logic [W-1:0] exp_res,
                        input logic exp_c, input logic exp_v,
                        input logic load, input logic err);
      exp_t e;
      @(negedge clock);
      #2;
      a      = ta;
      b      = tb;
      op_sel = top;
      if (load) begin
         m_q = exp_res;
         m_c = exp_c;
         m_v = exp_v;
      end
      e.res   = exp_res;
      e.res_q = m_q;
      e.carry = m_c;
      e.zero  = (m_q == '0);
      e.neg   = m_q[W-1];
      e.ovf   = m_v;
      e.err   = err;
      exp_q.push_back(e);
   endtask

   // Monitor: one expected entry per falling edge after each issued vector.
   initial begin
      exp_t e;
      forever begin
         @(negedge clock);
         if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            chk("result",   result,           e.res);
            chk("result_q", result_q,         e.res_q);
            chk("carry",    W'(carry),        W'(e.carry));
            chk("zero",     W'(zero),         W'(e.zero));
            chk("negative", W'(negative),     W'(e.neg));
            chk("overflow", W'(overflow),     W'(e.ovf));
            chk("op_error", W'(op_error),     W'(e.err));
         end
      end
   end

   // Driver: reset, directed vectors, mid-stream reset, drain, report.
   initial begin
      int wait_cycles;
      reset  = 1'b1;
      a      = '0;
      b      = '0;
      op_sel = '0;
      #1;
      chk("rst_result_q", result_q,     16'h0000);
      chk("rst_zero",     W'(zero),     16'h0001);
      chk("rst_carry",    W'(carry),    16'h0000);
      chk("rst_overflow", W'(overflow), 16'h0000);
      chk("rst_op_error", W'(op_error), 16'h0000);
      @(negedge clock);
      #2 reset = 1'b0;

      //     a         b         op        result    c     v     load  err
      issue(16'h0005, 16'h0001, 9'h008, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b0); // PC increment
      issue(16'hFFFF, 16'h0001, 9'h008, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0); // wrap
      issue(16'h7FFF, 16'h0001, 9'h008, 16'h8000, 1'b0, 1'b1, 1'b1, 1'b0); // signed ovf
      issue(16'h0000, 16'h0001, 9'h010, 16'hFFFF, 1'b1, 1'b0, 1'b1, 1'b0); // SUB borrow
      issue(16'h8000, 16'h0001, 9'h010, 16'h7FFF, 1'b0, 1'b1, 1'b1, 1'b0); // SUB ovf
      issue(16'h8001, 16'h0001, 9'h020, 16'h0002, 1'b1, 1'b0, 1'b1, 1'b0); // SHL
      issue(16'h8001, 16'h0001, 9'h040, 16'h4000, 1'b1, 1'b0, 1'b1, 1'b0); // SHR
      issue(16'h8001, 16'h0000, 9'h020, 16'h8001, 1'b0, 1'b0, 1'b1, 1'b0); // SHL by 0
      issue(16'hC000, 16'h000F, 9'h040, 16'h0001, 1'b1, 1'b0, 1'b1, 1'b0); // SHR by 15
      issue(16'h4000, 16'h0011, 9'h020, 16'h8000, 1'b0, 1'b0, 1'b1, 1'b0); // b[3:0] only
      issue(16'hF0F0, 16'hFF00, 9'h001, 16'hF000, 1'b0, 1'b0, 1'b1, 1'b0); // AND
      issue(16'hF0F0, 16'h0F0F, 9'h002, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0); // OR
      issue(16'hAAAA, 16'hFFFF, 9'h004, 16'h5555, 1'b0, 1'b0, 1'b1, 1'b0); // XOR
      issue(16'h00FF, 16'h1111, 9'h080, 16'hFF00, 1'b0, 1'b0, 1'b1, 1'b0); // NOT_A
      issue(16'h9999, 16'h1234, 9'h100, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0); // PASS_B
      issue(16'hFFFF, 16'h0001, 9'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); // no op: hold
`ifdef ALU_ONEHOT_CHECK_EN
      issue(16'h0003, 16'h0005, 9'h009, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b1); // multi-hot
`else
      issue(16'h0003, 16'h0005, 9'h009, 16'h0001, 1'b0, 1'b0, 1'b1, 1'b0); // AND wins
`endif
      issue(16'h0005, 16'h0001, 9'h008, 16'h0006, 1'b0, 1'b0, 1'b1, 1'b0); // error clears

      // Mid-stream asynchronous reset with result_q = 0x1234.
      issue(16'h0000, 16'h1234, 9'h100, 16'h1234, 1'b0, 1'b0, 1'b1, 1'b0);
      @(negedge clock);
      #3;
      chk("pre_rst_result_q", result_q, 16'h1234);
      reset = 1'b1;
      #1;
      chk("async_rst_result_q", result_q,     16'h0000);
      chk("async_rst_zero",     W'(zero),     16'h0001);
      chk("async_rst_negative", W'(negative), 16'h0000);
      m_q = '0;
      m_c = 1'b0;
      m_v = 1'b0;
      @(negedge clock);
      #2 reset = 1'b0;
      issue(16'hFFFE, 16'h0001, 9'h008, 16'hFFFF, 1'b0, 1'b0, 1'b1, 1'b0); // first load after reset
      issue(16'h0000, 16'h0000, 9'h000, 16'h0000, 1'b0, 1'b0, 1'b0, 1'b0); // hold

      wait_cycles = 0;
      while (exp_q.size() != 0 && wait_cycles < 20) begin
         @(posedge clock);
         wait_cycles++;
      end
      #6;
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
      end
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
